// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption engine. The key schedule runs forward to rk10,
// then unwinds backward one round key per cycle while a single shared
// inverse-round datapath processes the state. One block is in flight at a time.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; key and data_in sampled on accept
//   key, data_in        128-bit cipher key and ciphertext (byte 0 in [127:120])
//   out_valid/out_ready output handshake
//   data_out            128-bit plaintext, registered and held until taken
module aes_inv_cipher_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYEXP, S_WHITEN, S_ROUND, S_FINAL, S_DONE
  } state_e;

  localparam int unsigned RND_W = 4;

  // GF(2^8) arithmetic, polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] r;
    y = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // InvShiftRows then InvSubBytes; row r of column c comes from column c-r
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_e           state, state_d;
  logic [127:0]     sreg, sreg_d, kreg, kreg_d, data_out_d;
  logic [RND_W-1:0] rnd, rnd_d;
  logic             out_valid_d, accept;

  logic [31:0]      w0, w1, w2, w3, inv_w3, sw;
  logic [RND_W-1:0] rc_idx;
  logic [127:0]     fwd_key, inv_key, ark;

  assign in_ready = (state == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Shared key-schedule step: one SubWord serves both directions
  assign {w0, w1, w2, w3} = kreg;
  assign inv_w3 = w3 ^ w2;
  assign rc_idx = (state == S_WHITEN) ? RND_W'(10) : rnd;
  assign sw = sub_word((state == S_KEYEXP) ? {w3[23:0], w3[31:24]}
                                           : {inv_w3[23:0], inv_w3[31:24]})
              ^ {rcon(rc_idx), 24'h0};

  always_comb begin
    logic [31:0] f0, f1, f2;
    f0 = w0 ^ sw;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    fwd_key = {f0, f1, f2, w3 ^ f2};
  end

  assign inv_key = {w0 ^ sw, w1 ^ w0, w2 ^ w1, inv_w3};
  assign ark     = inv_sr_sb(sreg) ^ kreg;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sreg      <= '0;
      kreg      <= '0;
      rnd       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      sreg      <= sreg_d;
      kreg      <= kreg_d;
      rnd       <= rnd_d;
      data_out  <= data_out_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (accept) state_d = S_KEYEXP;
      S_KEYEXP: if (rnd == RND_W'(10)) state_d = S_WHITEN;
      S_WHITEN: state_d = S_ROUND;
      S_ROUND:  if (rnd == RND_W'(1)) state_d = S_FINAL;
      S_FINAL:  state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output register next values
  always_comb begin
    sreg_d      = sreg;
    kreg_d      = kreg;
    rnd_d       = rnd;
    data_out_d  = data_out;
    out_valid_d = out_valid;
    case (state)
      S_IDLE: begin
        if (accept) begin
          kreg_d = key;
          sreg_d = data_in;
          rnd_d  = RND_W'(1);
        end
      end
      S_KEYEXP: begin
        kreg_d = fwd_key;
        rnd_d  = rnd + RND_W'(1);
      end
      S_WHITEN: begin
        sreg_d = sreg ^ kreg;
        kreg_d = inv_key;
        rnd_d  = RND_W'(9);
      end
      S_ROUND: begin
        sreg_d = inv_mix_columns(ark);
        kreg_d = inv_key;
        rnd_d  = rnd - RND_W'(1);
      end
      S_FINAL: begin
        data_out_d  = ark;
        out_valid_d = 1'b1;
      end
      S_DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 vectors, latency,
// backpressure, busy rejection, mid-operation reset and a round trip against
// a behavioural AES-128 encryptor.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] key, data_in, data_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] sbox_t [256];

  aes_inv_cipher_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box by brute-force inverse search plus bitwise affine transform
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sbox_t[x] = b ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = sbox_t[s[4*((c+rr)%4)+rr]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Offer one block, wait for out_valid; optional noise on the input side while busy
  task automatic run_block(input logic [127:0] k, input logic [127:0] ct, input bit noise,
                           output logic [127:0] pt, output int lat, output int busy_acc);
    key = k; data_in = ct; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = -1;
    busy_acc = 0;
    for (int i = 1; i <= 100; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        key      = {$urandom(), $urandom(), $urandom(), $urandom()};
        data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (in_valid && in_ready) busy_acc++;
      end
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    in_valid = 1'b0;
    pt = data_out;
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 128'(out_valid), 128'(0));
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] pt, k, p;
    int lat, busy, bad;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key = '0; data_in = '0;
    build_sbox();
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1 with latency
    run_block(C1_KEY, C1_CT, 1'b0, pt, lat, busy);
    chk("c1_latency", 128'(lat), 128'(21));
    chk("c1_data", pt, C1_PT);
    take("c1");

    // FIPS-197 Appendix B
    run_block(B_KEY, B_CT, 1'b0, pt, lat, busy);
    chk("appb_data", pt, B_PT);
    take("appb");

    // Backpressure: output held for 50 cycles
    run_block(C1_KEY, C1_CT, 1'b0, pt, lat, busy);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (data_out !== C1_PT || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    chk("bp_hold_violations", 128'(bad), 128'(0));
    take("bp");

    // Busy rejection with input noise
    run_block(C1_KEY, C1_CT, 1'b1, pt, lat, busy);
    chk("busy_accepts", 128'(busy), 128'(0));
    chk("busy_data", pt, C1_PT);
    take("busy");

    // Reset in ROUND aborts the block
    key = C1_KEY; data_in = C1_CT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_data_out", data_out, 128'(0));
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("midrst_no_output", 128'(bad), 128'(0));
    chk("midrst_idle", 128'(in_ready), 128'(1));
    run_block(B_KEY, B_CT, 1'b0, pt, lat, busy);
    chk("midrst_appb_data", pt, B_PT);
    take("midrst_appb");

    // Round trip against the behavioural encryptor
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(k, aes_enc(k, p), 1'b0, pt, lat, busy);
      chk($sformatf("rt%0d_data", n), pt, p);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
